// File: rtl/addsub_serial.sv
// ============================================================================
// Module   : addsub_serial
// Purpose  : Multi-cycle two's-complement add/sub, CHUNK bits per clock, with
//            a valid/ready handshake on both sides and carry/overflow/zero
//            flags. Optional macro ADDSUB_SAT_EN clamps on signed overflow.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_res;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic               w_accept;
  logic               w_last;
  logic [CHUNK-1:0]   w_a_chk;
  logic [CHUNK-1:0]   w_b_chk;
  logic [CHUNK:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_pres;

  // Reset gates in_ready so nothing is accepted while rst is held.
  assign in_ready  = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    out_valid   = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = w_accept ? S_CALC : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One CHUNK-wide slice of the ripple adder, selected by the chunk counter.
  always_comb begin
    w_a_chk   = r_a[r_cnt*CHUNK +: CHUNK];
    w_b_chk   = r_b[r_cnt*CHUNK +: CHUNK];
    w_sum     = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
    w_acc_nxt = r_acc;
    w_acc_nxt[r_cnt*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
  end

  assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_acc_nxt[WIDTH-1] != r_a[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
  always_comb begin
    w_pres = w_acc_nxt;
    if (w_ovf) begin
      w_pres = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_pres = w_acc_nxt;
`endif

  // Partial sums live in r_acc; the visible result only updates on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{mode}};
      r_carry <= mode;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_acc   <= w_acc_nxt;
      r_carry <= w_sum[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_res  <= w_pres;
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_ovf;
        r_zero <= (w_pres == '0);
      end
    end
  end

  assign result    = r_res;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

`default_nettype wire
